// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, command bytes, bus widths.
package prog_loader_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] CMD_INSTR = 8'h01;
  localparam logic [7:0] CMD_DATA  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h0F;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StByte,
    StCsum,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  // Counter width able to hold max_val - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory-load bus of the program loader.
// master: loader side (accepts the stream, drives the core); slave: stream source and core side.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] instruction;
  logic [ADDR_W-1:0] instructionAddress;
  logic [WORD_W-1:0] data;
  logic [ADDR_W-1:0] dataAddress;
  logic              writeEnable;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output instruction,
    output instructionAddress,
    output data,
    output dataAddress,
    output writeEnable
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  instruction,
    input  instructionAddress,
    input  data,
    input  dataAddress,
    input  writeEnable
  );

endinterface

// File: rtl/prog_loader_timer.sv
// Load-and-count-down delay counter; expired_o is high once the count reaches zero.
module prog_loader_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Turns a framed byte stream into word writes with setup/pulse/hold timing around writeEnable.
// Define PROG_LOADER_CHECKSUM_EN to require an XOR checksum byte on every write frame.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  prog_loader_if.master    bus_io,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       word_count
);

  localparam int unsigned MaxCycles =
      (SETUP_CYCLES > PULSE_CYCLES)
        ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
        : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int unsigned TimerW = cnt_width(MaxCycles);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] instr_q, instr_d, data_q, data_d, shreg_q, shreg_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d, daddr_q, daddr_d, addr_q, addr_d;
  logic              tgt_data_q, tgt_data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              done_q, done_d, err_q, err_d;
  logic [7:0]        wc_q, wc_d;
  logic              fire, launch;
  logic              timer_load, timer_expired;
  logic [TimerW-1:0] timer_val;

  assign fire = bus_io.in_valid && in_ready_q;

  prog_loader_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    addr_d     = addr_q;
    tgt_data_d = tgt_data_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    instr_d    = instr_q;
    iaddr_d    = iaddr_q;
    data_d     = data_q;
    daddr_d    = daddr_q;
    done_d     = done_q;
    err_d      = err_q;
    wc_d       = wc_q;
    launch     = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;

    unique case (state_q)
      StIdle: begin
        if (fire) begin
          csum_d = bus_io.in_data;
          if (bus_io.in_data == CMD_INSTR || bus_io.in_data == CMD_DATA) begin
            tgt_data_d = (bus_io.in_data == CMD_DATA);
            state_d    = StAddr;
          end else if (bus_io.in_data == CMD_START) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (fire) begin
          addr_d  = bus_io.in_data[ADDR_W-1:0];
          csum_d  = csum_q ^ bus_io.in_data;
          cnt_d   = 2'd0;
          state_d = StByte;
        end
      end
      StByte: begin
        if (fire) begin
          shreg_d = {shreg_q[WORD_W-9:0], bus_io.in_data};
          csum_d  = csum_q ^ bus_io.in_data;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            launch = 1'b1;
`endif
          end
        end
      end
      StCsum: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (fire) begin
          if (bus_io.in_data == csum_q) begin
            launch = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StSetup: begin
        if (timer_expired) begin
          timer_load = 1'b1;
          timer_val  = TimerW'(PULSE_CYCLES - 1);
          state_d    = StStrobe;
        end
      end
      StStrobe: begin
        if (timer_expired) begin
          timer_load = 1'b1;
          timer_val  = TimerW'(HOLD_CYCLES - 1);
          state_d    = StHold;
        end
      end
      StHold: begin
        if (timer_expired) begin
          wc_d    = (wc_q == 8'hFF) ? wc_q : wc_q + 8'd1;
          state_d = StIdle;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase

    // Only the targeted bus is updated; the other keeps its last word for the idempotent rewrite.
    if (launch) begin
      state_d    = StSetup;
      timer_load = 1'b1;
      timer_val  = TimerW'(SETUP_CYCLES - 1);
      if (tgt_data_q) begin
        data_d  = shreg_d;
        daddr_d = addr_q;
      end else begin
        instr_d = shreg_d;
        iaddr_d = addr_q;
      end
    end
  end

  assign in_ready_d = (state_d == StIdle) || (state_d == StAddr) || (state_d == StByte) ||
                      (state_d == StCsum);
  assign we_d       = (state_d == StStrobe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      instr_q    <= '0;
      iaddr_q    <= '0;
      data_q     <= '0;
      daddr_q    <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      tgt_data_q <= 1'b0;
      cnt_q      <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      instr_q    <= instr_d;
      iaddr_q    <= iaddr_d;
      data_q     <= data_d;
      daddr_q    <= daddr_d;
      shreg_q    <= shreg_d;
      addr_q     <= addr_d;
      tgt_data_q <= tgt_data_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wc_q       <= wc_d;
    end
  end

  assign bus_io.in_ready           = in_ready_q;
  assign bus_io.writeEnable        = we_q;
  assign bus_io.instruction        = instr_q;
  assign bus_io.instructionAddress = iaddr_q;
  assign bus_io.data               = data_q;
  assign bus_io.dataAddress        = daddr_q;

  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame table, random frames against a
// frame-level model, strobe timing monitor, start and reset-mid-strobe sequences.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int SETUP_C = 2;
  localparam int PULSE_C = 2;
  localparam int HOLD_C  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, done, err;
  logic [7:0] word_count;

  prog_loader_if bus_if ();

  prog_loader #(
    .SETUP_CYCLES(SETUP_C),
    .PULSE_CYCLES(PULSE_C),
    .HOLD_CYCLES (HOLD_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_io    (bus_if),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Frame-level reference model
  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  iaddr;
    logic [31:0] data;
    logic [6:0]  daddr;
  } snap_t;

  logic [31:0] m_instr, m_data;
  logic [6:0]  m_iaddr, m_daddr;
  int          m_wc;
  logic        m_err, m_done;
  snap_t       exp_q[$];
  int          acc_cyc = 0;
  int          strb_base = 0;
  int          exp_frame_strobes = 0;
  bit          in_write = 0;

  task automatic model_reset();
    m_instr = '0; m_data = '0; m_iaddr = '0; m_daddr = '0;
    m_wc = 0; m_err = 1'b0; m_done = 1'b0;
    exp_q.delete();
  endtask

  // Strobe monitor
  snap_t cur, bus_prev;
  logic  we_prev = 1'b0;
  int    rise_cyc = 0, fall_cyc = -100, last_chg = 0, n_strobes = 0;
  snap_t e;

  always @(negedge clk) begin
    cur = {bus_if.instruction, bus_if.instructionAddress, bus_if.data, bus_if.dataAddress};
    if (rst) begin
      we_prev  = 1'b0;
      bus_prev = '0;
      last_chg = cyc;
      fall_cyc = -100;
    end else begin
      if (bus_if.writeEnable && !we_prev) begin
        n_strobes++;
        rise_cyc = cyc;
        check("strobe latency", 64'(cyc - acc_cyc), 64'(SETUP_C));
        check("setup time", 64'(cyc - last_chg >= SETUP_C), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected strobe", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe instr", 64'(cur.instr), 64'(e.instr));
          check("strobe iaddr", 64'(cur.iaddr), 64'(e.iaddr));
          check("strobe data", 64'(cur.data), 64'(e.data));
          check("strobe daddr", 64'(cur.daddr), 64'(e.daddr));
        end
      end
      if (!bus_if.writeEnable && we_prev) begin
        check("pulse width", 64'(cyc - rise_cyc), 64'(PULSE_C));
        fall_cyc = cyc;
      end
      if (cur != bus_prev) begin
        check("bus stable in strobe/hold",
              64'(bus_if.writeEnable || we_prev || (cyc < fall_cyc + HOLD_C)), 64'd0);
        last_chg = cyc;
      end
      if (in_write) begin
        if (!busy) in_write = 0;
        else check("in_ready low during write", 64'(bus_if.in_ready), 64'd0);
      end
      we_prev  = bus_if.writeEnable;
      bus_prev = cur;
    end
  end

  // Stream driver
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
    end
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (bus_if.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    bus_if.in_valid = 1'b0;
    if (!ok) check("byte accept timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [31:0] word, input int gap, input bit bad_csum);
    bit good;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] cs;
`endif
    good = (cmd == CMD_INSTR) || (cmd == CMD_DATA);
    strb_base = n_strobes;
    exp_frame_strobes = 0;
    if (good && !bad_csum) begin
      if (cmd == CMD_INSTR) begin
        m_instr = word; m_iaddr = addr[6:0];
      end else begin
        m_data = word; m_daddr = addr[6:0];
      end
      if (m_wc < 255) m_wc++;
      exp_q.push_back({m_instr, m_iaddr, m_data, m_daddr});
      exp_frame_strobes = 1;
    end else if (cmd == CMD_START) begin
      m_done = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    send_byte(cmd, gap);
    if (good) begin
      send_byte(addr, gap);
      for (int i = 3; i >= 0; i--) send_byte(word[i*8 +: 8], gap);
`ifdef PROG_LOADER_CHECKSUM_EN
      cs = cmd ^ addr ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
      send_byte(bad_csum ? ~cs : cs, gap);
`endif
      if (!bad_csum) in_write = 1;
    end
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) check("idle timeout", 64'd0, 64'd1);
  endtask

  task automatic check_model(input string name);
    check({name, " instr"}, 64'(bus_if.instruction), 64'(m_instr));
    check({name, " iaddr"}, 64'(bus_if.instructionAddress), 64'(m_iaddr));
    check({name, " data"}, 64'(bus_if.data), 64'(m_data));
    check({name, " daddr"}, 64'(bus_if.dataAddress), 64'(m_daddr));
    check({name, " word_count"}, 64'(word_count), 64'(m_wc));
    check({name, " err"}, 64'(err), 64'(m_err));
    check({name, " done"}, 64'(done), 64'(m_done));
    check({name, " strobes"}, 64'(n_strobes - strb_base), 64'(exp_frame_strobes));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " writeEnable"}, 64'(bus_if.writeEnable), 64'd0);
    check({name, " in_ready"}, 64'(bus_if.in_ready), 64'd0);
    check({name, " instr"}, 64'(bus_if.instruction), 64'd0);
    check({name, " iaddr"}, 64'(bus_if.instructionAddress), 64'd0);
    check({name, " data"}, 64'(bus_if.data), 64'd0);
    check({name, " daddr"}, 64'(bus_if.dataAddress), 64'd0);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " done"}, 64'(done), 64'd0);
    check({name, " err"}, 64'(err), 64'd0);
    check({name, " word_count"}, 64'(word_count), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] word;
    int          gap;
    logic [31:0] e_instr;
    logic [6:0]  e_iaddr;
    logic [31:0] e_data;
    logic [6:0]  e_daddr;
    logic        e_err;
    int          e_wc;
    int          e_strobes;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] c, bad;
    bit         ok;

    vecs[0] = '{8'h01, 8'h05, 32'h20110020, 0, 32'h20110020, 7'h05, 32'h0, 7'h00, 1'b0, 1, 1};
    vecs[1] = '{8'h02, 8'h83, 32'h0000002A, 0, 32'h20110020, 7'h05, 32'h2A, 7'h03, 1'b0, 2, 1};
    vecs[2] = '{8'h07, 8'h00, 32'h0, 0, 32'h20110020, 7'h05, 32'h2A, 7'h03, 1'b1, 2, 0};
    vecs[3] = '{8'h01, 8'h7F, 32'hDEADBEEF, 0, 32'hDEADBEEF, 7'h7F, 32'h2A, 7'h03, 1'b1, 3, 1};
    vecs[4] = '{8'h01, 8'h05, 32'h20110020, 2, 32'h20110020, 7'h05, 32'h2A, 7'h03, 1'b1, 4, 1};

    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 64'(bus_if.in_ready), 64'd1);

    foreach (vecs[i]) begin
      send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].word, vecs[i].gap, 1'b0);
      wait_idle();
      check("vec instr", 64'(bus_if.instruction), 64'(vecs[i].e_instr));
      check("vec iaddr", 64'(bus_if.instructionAddress), 64'(vecs[i].e_iaddr));
      check("vec data", 64'(bus_if.data), 64'(vecs[i].e_data));
      check("vec daddr", 64'(bus_if.dataAddress), 64'(vecs[i].e_daddr));
      check("vec err", 64'(err), 64'(vecs[i].e_err));
      check("vec word_count", 64'(word_count), 64'(vecs[i].e_wc));
      check("vec strobes", 64'(n_strobes - strb_base), 64'(vecs[i].e_strobes));
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    send_frame(8'h02, 8'h10, 32'h12345678, 0, 1'b1);
    wait_idle();
    check_model("bad checksum");
    send_frame(8'h01, 8'h11, 32'hA5A5A5A5, 0, 1'b0);
    wait_idle();
    check_model("after bad checksum");
`endif

    do_reset();
    for (int f = 0; f < 330; f++) begin
      c = 8'($urandom_range(0, 9));
      if (c < 5) c = CMD_INSTR;
      else if (c < 9) c = CMD_DATA;
      else begin
        bad = 8'($urandom);
        while (bad == CMD_INSTR || bad == CMD_DATA || bad == CMD_START) bad = 8'($urandom);
        c = bad;
      end
      send_frame(c, 8'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0, 1'b0);
      wait_idle();
      check_model("random");
    end

    // Reset during the first strobe cycle must drop writeEnable asynchronously.
    do_reset();
    send_frame(8'h01, 8'h11, 32'hCAFEF00D, 0, 1'b0);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(posedge clk);
      #1;
      if (bus_if.writeEnable) ok = 1;
    end
    check("strobe seen before reset", 64'(ok), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("reset mid-strobe");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after mid-strobe reset", 64'(bus_if.in_ready), 64'd1);

    send_frame(CMD_START, 8'h00, 32'h0, 0, 1'b0);
    wait_idle();
    check_model("start");
    check("in_ready after start", 64'(bus_if.in_ready), 64'd0);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = CMD_INSTR;
    repeat (8) @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("in_ready stays low in done", 64'(bus_if.in_ready), 64'd0);
    check("done sticky", 64'(done), 64'd1);
    check("busy in done", 64'(busy), 64'd0);
    check("no write in done", 64'(word_count), 64'(m_wc));
    rst = 1'b1;
    #1;
    check_all_zero("reset from done");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after done reset", 64'(bus_if.in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
